// File: rtl/filter_ctrl_pkg.sv
// Shared types and widths for the filter stream controller.
//   state_e : raster sequencer states
//   cfg_t   : frame configuration captured at frame boundaries
//   cfg_valid() : a frame can only start with nonzero width and height
package filter_ctrl_pkg;

  localparam int unsigned LineSizeMax   = 4096;
  localparam int unsigned FrameLinesMax = 4096;
  localparam int unsigned PixelW        = 8;
  localparam int unsigned BlankW        = 12;
  localparam int unsigned WidthW        = $clog2(LineSizeMax + 1);
  localparam int unsigned HeightW       = $clog2(FrameLinesMax + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINE,
    S_HBLANK,
    S_VBLANK
  } state_e;

  typedef struct packed {
    logic [WidthW-1:0]  width;
    logic [HeightW-1:0] height;
    logic [BlankW-1:0]  gap;
    logic [BlankW-1:0]  hblank;
    logic [BlankW-1:0]  vblank;
    logic               bypass;
  } cfg_t;

  function automatic logic cfg_valid(input logic [WidthW-1:0]  width,
                                     input logic [HeightW-1:0] height);
    return (width != '0) && (height != '0);
  endfunction

endpackage

// File: rtl/filter_ctrl_blank_cnt.sv
// Loadable down-counter used for the pixel gap and the line/frame blanking.
//   clk, rst_n  : clock, synchronous active-low reset
//   clear_i     : force count to zero (highest priority)
//   load_i      : load load_val_i
//   load_val_i  : value to load
//   last_o      : count is 0 or equals LastAt; with LastAt=1 a load of 0 or 1
//                 both give a single-cycle interval
module filter_ctrl_blank_cnt
  import filter_ctrl_pkg::*;
#(
  parameter int unsigned Width  = BlankW,
  parameter int unsigned LastAt = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             last_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0) || (cnt_q == Width'(LastAt));

endmodule

// File: rtl/filter_stream_ctrl.sv
// Frame sequencer feeding the 5x5 filters: turns a valid/ready pixel stream into
// a de/hs/vs raster with programmable size, per-pixel gap and blanking. All cfg
// is captured only at frame boundaries. Size parameters must match the package
// defaults, which size the shadow configuration.
//   clk, rst_n        : clock, synchronous active-low reset
//   enable_i          : run frames (checked at frame boundaries only)
//   cfg_*_i           : width, height, gap, hblank, vblank, bypass request
//   di_i/valid_i      : source pixel; ready_o accepts it
//   do_o/de_o/hs_o/vs_o : registered raster to the filter
//   bypass_o          : latched bypass for the filter
//   busy_o            : frame in progress
//   frame_done_o      : pulse on the last frame-blank cycle
//   cfg_err_o         : pulse when enabled with zero width or height
module filter_stream_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int unsigned LINE_SIZE_MAX   = LineSizeMax,
  parameter int unsigned FRAME_LINES_MAX = FrameLinesMax,
  parameter int unsigned PIXEL_WIDTH     = PixelW,
  parameter int unsigned BLANK_WIDTH     = BlankW
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable_i,
  input  logic [$clog2(LINE_SIZE_MAX+1)-1:0]   cfg_width_i,
  input  logic [$clog2(FRAME_LINES_MAX+1)-1:0] cfg_height_i,
  input  logic [BLANK_WIDTH-1:0]               cfg_gap_i,
  input  logic [BLANK_WIDTH-1:0]               cfg_hblank_i,
  input  logic [BLANK_WIDTH-1:0]               cfg_vblank_i,
  input  logic                                 cfg_bypass_i,
  input  logic [PIXEL_WIDTH-1:0]               di_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  output logic [PIXEL_WIDTH-1:0]               do_o,
  output logic                                 de_o,
  output logic                                 hs_o,
  output logic                                 vs_o,
  output logic                                 bypass_o,
  output logic                                 busy_o,
  output logic                                 frame_done_o,
  output logic                                 cfg_err_o
);

  localparam int unsigned XW = $clog2(LINE_SIZE_MAX + 1);
  localparam int unsigned YW = $clog2(FRAME_LINES_MAX + 1);

  state_e                 state_q, state_d;
  cfg_t                   cfg_q, cfg_d, cfg_in;
  logic [XW-1:0]          x_q, x_d, x_max;
  logic [YW-1:0]          y_q, y_d, y_max;
  logic [PIXEL_WIDTH-1:0] do_q, do_d;
  logic                   de_q, de_d;
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   cfg_ok, start, xfer;
  logic                   gap_idle, gap_load, gap_clear;
  logic                   blk_last, blk_load;
  logic [BLANK_WIDTH-1:0] blk_val;

  assign cfg_in = '{width:  cfg_width_i,
                    height: cfg_height_i,
                    gap:    cfg_gap_i,
                    hblank: cfg_hblank_i,
                    vblank: cfg_vblank_i,
                    bypass: cfg_bypass_i};
  assign cfg_ok = cfg_valid(cfg_width_i, cfg_height_i);

  // Compares use the shadow copy; width/height are never zero once latched.
  assign x_max = XW'(cfg_q.width) - XW'(1);
  assign y_max = YW'(cfg_q.height) - YW'(1);

  assign ready_o = (state_q == S_LINE) && gap_idle;
  assign xfer    = ready_o && valid_i;

  // Gap: ready again once the count reaches zero, giving G idle cycles.
  filter_ctrl_blank_cnt #(
    .Width  (BLANK_WIDTH),
    .LastAt (0)
  ) u_gap_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (gap_clear),
    .load_i     (gap_load),
    .load_val_i (cfg_q.gap),
    .last_o     (gap_idle)
  );

  // Shared by line and frame blanking; a load of 0 still lasts one cycle.
  filter_ctrl_blank_cnt #(
    .Width  (BLANK_WIDTH),
    .LastAt (1)
  ) u_blank_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (1'b0),
    .load_i     (blk_load),
    .load_val_i (blk_val),
    .last_o     (blk_last)
  );

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    x_d          = x_q;
    y_d          = y_q;
    do_d         = do_q;
    de_d         = 1'b0;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    gap_load     = 1'b0;
    gap_clear    = 1'b0;
    blk_load     = 1'b0;
    blk_val      = cfg_q.hblank;
    start        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          if (cfg_ok) start = 1'b1;
          else        cfg_err_d = 1'b1;
        end
      end
      S_LINE: begin
        if (xfer) begin
          de_d     = 1'b1;
          do_d     = di_i;
          gap_load = 1'b1;
          if (x_q == x_max) begin
            blk_load = 1'b1;
            if (y_q == y_max) begin
              blk_val = cfg_q.vblank;
              state_d = S_VBLANK;
            end else begin
              y_d     = y_q + YW'(1);
              state_d = S_HBLANK;
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_HBLANK: begin
        if (blk_last) begin
          x_d     = '0;
          state_d = S_LINE;
        end
      end
      S_VBLANK: begin
        if (blk_last) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
          if (enable_i) begin
            if (cfg_ok) start = 1'b1;
            else        cfg_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d   = S_LINE;
      cfg_d     = cfg_in;
      x_d       = '0;
      y_d       = '0;
      gap_clear = 1'b1;
    end
  end

  // hs/vs follow the state one cycle late so they line up with registered de.
  assign hs_d   = (state_q != S_LINE);
  assign vs_d   = (state_q == S_LINE) || (state_q == S_HBLANK);
  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cfg_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      do_q         <= '0;
      de_q         <= 1'b0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      x_q          <= x_d;
      y_q          <= y_d;
      do_q         <= do_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign do_o         = do_q;
  assign de_o         = de_q;
  assign hs_o         = hs_q;
  assign vs_o         = vs_q;
  assign bypass_o     = cfg_q.bypass;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_filter_stream_ctrl.sv
// Scoreboard bench for filter_stream_ctrl: the source pushes every accepted
// pixel into a queue, a monitor pops on each de_o; raster timing, line lengths
// and control pulses are checked against hand-derived values.
module tb_filter_stream_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable_i;
  logic [12:0] cfg_width_i;
  logic [12:0] cfg_height_i;
  logic [11:0] cfg_gap_i;
  logic [11:0] cfg_hblank_i;
  logic [11:0] cfg_vblank_i;
  logic        cfg_bypass_i;
  logic [7:0]  di_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  do_o;
  logic        de_o;
  logic        hs_o;
  logic        vs_o;
  logic        bypass_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        cfg_err_o;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  int          line_len_q[$];
  int          line_de;
  logic        stall;
  logic        hs_prev;

  filter_stream_ctrl u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .cfg_width_i  (cfg_width_i),
    .cfg_height_i (cfg_height_i),
    .cfg_gap_i    (cfg_gap_i),
    .cfg_hblank_i (cfg_hblank_i),
    .cfg_vblank_i (cfg_vblank_i),
    .cfg_bypass_i (cfg_bypass_i),
    .di_i         (di_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .do_o         (do_o),
    .de_o         (de_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o),
    .bypass_o     (bypass_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .cfg_err_o    (cfg_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, ready_o, 0);
    check({tag, "_do"}, do_o, 0);
    check({tag, "_de"}, de_o, 0);
    check({tag, "_hs"}, hs_o, 1);
    check({tag, "_vs"}, vs_o, 0);
    check({tag, "_bypass"}, bypass_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_frame_done"}, frame_done_o, 0);
    check({tag, "_cfg_err"}, cfg_err_o, 0);
  endtask

  function automatic logic cond(input int what);
    case (what)
      0:       return de_o === 1'b1;
      1:       return frame_done_o === 1'b1;
      default: return busy_o === 1'b0;
    endcase
  endfunction

  // Returns at the negedge where the condition holds (or the budget ran out).
  task automatic wait_for(input int what, input int budget, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!cond(what) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reached"}, cond(what), 1);
  endtask

  // First 'split' lines expected la long, the rest lb long.
  task automatic check_lines(input int n, input int split, input int la, input int lb);
    check("line_count", line_len_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check("line_len", (i < line_len_q.size()) ? line_len_q[i] : -1, (i < split) ? la : lb);
    end
  endtask

  task automatic set_cfg(input int w, input int h, input int g, input int hb, input int vb,
                         input logic byp);
    cfg_width_i  = 13'(w);
    cfg_height_i = 13'(h);
    cfg_gap_i    = 12'(g);
    cfg_hblank_i = 12'(hb);
    cfg_vblank_i = 12'(vb);
    cfg_bypass_i = byp;
  endtask

  // Source: always valid unless stalled; records every accepted pixel.
  initial begin : source
    logic took;
    valid_i = 1'b0;
    di_i    = 8'h11;
    forever begin
      @(negedge clk);
      took = rst_n && valid_i && ready_o;
      if (took) exp_q.push_back(di_i);
      @(posedge clk);
      #1;
      if (took) di_i = di_i + 8'd37;
      valid_i = !stall;
    end
  end

  // Monitor: pops the scoreboard on every de_o and measures line lengths.
  initial begin : monitor
    logic [7:0] e;
    hs_prev = 1'b1;
    line_de = 0;
    forever begin
      @(negedge clk);
      if (de_o === 1'b1) begin
        line_de++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_de: actual=%0h required=no_pixel", do_o);
        end else begin
          e = exp_q.pop_front();
          check("pixel", do_o, e);
        end
        check("raster_at_de", {hs_o, vs_o}, 2'b01);
      end
      if (hs_o === 1'b1 && hs_prev === 1'b0) begin
        line_len_q.push_back(line_de);
        line_de = 0;
      end
      hs_prev = hs_o;
    end
  end

  initial begin : main
    int   cnt;
    int   n;
    int   p;
    logic d;

    rst_n    = 1'b0;
    enable_i = 1'b0;
    stall    = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero height: error pulses while enabled, controller stays idle.
    set_cfg(4, 0, 0, 5, 7, 1'b0);
    enable_i = 1'b1;
    repeat (3) @(negedge clk);
    check("zero_cfg_err", cfg_err_o, 1);
    check("zero_busy", busy_o, 0);
    check("zero_hs", hs_o, 1);
    check("zero_ready", ready_o, 0);
    @(posedge clk);
    #1 enable_i = 1'b0;
    repeat (2) @(negedge clk);
    check("zero_err_clear", cfg_err_o, 0);

    // Basic 4x3 frame, gap 0, hblank 5, vblank 7: 29-cycle frame period.
    @(posedge clk);
    #1;
    set_cfg(4, 3, 0, 5, 7, 1'b1);
    line_len_q.delete();
    line_de  = 0;
    enable_i = 1'b1;
    wait_for(0, 20, "basic_start");
    for (int k = 0; k < 58; k++) begin
      p = k % 29;
      d = (p < 4) || (p >= 9 && p < 13) || (p >= 18 && p < 22);
      check("basic_raster", {de_o, hs_o, vs_o, frame_done_o}, {d, !d, p < 22, p == 28});
      @(negedge clk);
    end
    check("basic_bypass", bypass_o, 1);
    check("basic_busy", busy_o, 1);
    @(posedge clk);
    #1 enable_i = 1'b0;
    wait_for(2, 200, "basic_idle");
    check_lines(9, 9, 4, 4);

    // Gap 3: de every 4 cycles, next line after 5*4-3+5 = 22 cycles.
    @(posedge clk);
    #1;
    set_cfg(5, 2, 3, 5, 2, 1'b0);
    line_len_q.delete();
    line_de  = 0;
    enable_i = 1'b1;
    wait_for(0, 20, "gap_start");
    for (int k = 0; k < 23; k++) begin
      check("gap_de", de_o, (k < 17 && k % 4 == 0) || k == 22);
      @(negedge clk);
    end
    @(posedge clk);
    #1 enable_i = 1'b0;
    wait_for(2, 200, "gap_idle");
    check_lines(2, 2, 5, 5);
    check("gap_bypass", bypass_o, 0);

    // Source stall mid-line: raster holds, no de, line length unaffected.
    @(posedge clk);
    #1;
    set_cfg(8, 2, 0, 3, 3, 1'b0);
    line_len_q.delete();
    line_de  = 0;
    enable_i = 1'b1;
    wait_for(0, 20, "stall_start");
    @(posedge clk);
    #1 enable_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("stall_raster", {de_o, hs_o, vs_o}, 3'b001);
    end
    stall = 1'b0;
    wait_for(2, 200, "stall_idle");
    check_lines(2, 2, 8, 8);

    // Mid-frame cfg change only takes effect from the next frame.
    @(posedge clk);
    #1;
    set_cfg(4, 2, 0, 2, 2, 1'b0);
    line_len_q.delete();
    line_de  = 0;
    enable_i = 1'b1;
    wait_for(0, 20, "cfgchg_start");
    cfg_width_i  = 13'd6;
    cfg_bypass_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("cfgchg_bypass_hold", bypass_o, 0);
    end
    wait_for(1, 100, "cfgchg_done");
    check("cfgchg_bypass_new", bypass_o, 1);
    @(posedge clk);
    #1 enable_i = 1'b0;
    wait_for(2, 200, "cfgchg_idle");
    check_lines(4, 2, 4, 6);

    // Reset mid-line on the second line, then a clean restart.
    @(posedge clk);
    #1;
    set_cfg(4, 3, 0, 2, 2, 1'b1);
    line_len_q.delete();
    line_de  = 0;
    enable_i = 1'b1;
    wait_for(0, 20, "rst_start");
    cnt = 0;
    n   = 0;
    while (cnt < 5 && n < 60) begin
      @(negedge clk);
      n++;
      if (de_o === 1'b1) cnt++;
    end
    check("rst_reach", cnt, 5);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset("mid");
    @(posedge clk);
    line_len_q.delete();
    line_de = 0;
    wait_for(0, 20, "rst_restart");
    @(posedge clk);
    #1 enable_i = 1'b0;
    wait_for(2, 200, "rst_idle");
    check_lines(3, 3, 4, 4);
    check("rst_bypass", bypass_o, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
